// File: rtl/ptcfg_pkg.sv
// Shared types and constants for the product-term configuration loader.
package ptcfg_pkg;

  localparam int PT_BITS      = 96;
  localparam int BYTES_PER_PT = 12;
  localparam int ADDR_W       = 7;
  localparam int BIDX_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[7-j];
    return r;
  endfunction

endpackage

// File: rtl/ptcfg_shifter.sv
// Byte-to-word assembler: drops each received byte into its 8-bit lane of the
// 96-bit product-term word, MSB of the byte landing on the lowest lane index.
module ptcfg_shifter
  import ptcfg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [BIDX_W-1:0]  byte_idx_i,
  input  logic [7:0]         byte_i,
  output logic [PT_BITS-1:0] word_o
);

  logic [PT_BITS-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    for (int k = 0; k < BYTES_PER_PT; k++) begin
      if (load_i && (byte_idx_i == BIDX_W'(k))) word_d[8*k +: 8] = bit_rev8(byte_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/ptcfg_loader.sv
// Streams 12 bytes per product term into a bitmap store, NUM_PT terms per load.
// Optional trailing XOR checksum byte when PTCFG_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting bytes of the current product term
// COMMIT | one-cycle write of the assembled term
// CHECK  | accepting the checksum trailer (checksum build only)
// DONE   | one-cycle completion pulse
module ptcfg_loader
  import ptcfg_pkg::*;
#(
  parameter int NUM_PT = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_data,
  output logic               cfg_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PT_BITS-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               crc_err
);

  localparam logic [7:0]        LAST_PT   = 8'(NUM_PT);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_PT - 1);

  state_e              state_q, state_d;
  logic [BIDX_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]          pt_cnt_q, pt_cnt_d;
  logic [7:0]          pt_inc;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [PT_BITS-1:0]  data_hold_q, data_hold_d;
  logic [PT_BITS-1:0]  asm_word;
  logic                shift_load;
`ifdef PTCFG_CHECKSUM_EN
  logic [7:0]          acc_q, acc_d;
  logic                crc_err_q, crc_err_d;
`endif

  assign pt_inc = pt_cnt_q + 8'd1;

  ptcfg_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (shift_load),
    .byte_idx_i (byte_cnt_q),
    .byte_i     (cfg_data),
    .word_o     (asm_word)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    cfg_ready   = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    shift_load  = 1'b0;
`ifdef PTCFG_CHECKSUM_EN
    acc_d       = acc_q;
    crc_err_d   = crc_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_LOAD;
          byte_cnt_d = '0;
          pt_cnt_d   = '0;
`ifdef PTCFG_CHECKSUM_EN
          acc_d      = '0;
          crc_err_d  = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cfg_valid) begin
          shift_load = 1'b1;
`ifdef PTCFG_CHECKSUM_EN
          acc_d = acc_q ^ cfg_data;
`endif
          if (byte_cnt_q == LAST_BYTE) state_d = ST_COMMIT;
          else                         byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          wr_en       = 1'b1;
          addr_hold_d = pt_cnt_q[ADDR_W-1:0];
          data_hold_d = asm_word;
          pt_cnt_d    = pt_inc;
          byte_cnt_d  = '0;
          if (pt_inc == LAST_PT) begin
`ifdef PTCFG_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_CHECK: begin
`ifdef PTCFG_CHECKSUM_EN
        cfg_ready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cfg_valid) begin
          crc_err_d = (cfg_data != acc_q);
          state_d   = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      pt_cnt_q    <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pt_cnt_q    <= pt_cnt_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

`ifdef PTCFG_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      crc_err_q <= crc_err_d;
    end
  end
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  // The assembled word is presented live during COMMIT and held afterwards.
  assign wr_addr = (state_q == ST_COMMIT) ? pt_cnt_q[ADDR_W-1:0] : addr_hold_q;
  assign wr_data = (state_q == ST_COMMIT) ? asm_word : data_hold_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ptcfg_loader.sv
// Directed bench for ptcfg_loader with a write scoreboard (NUM_PT = 2).
module tb_ptcfg_loader;

  localparam int NPT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cfg_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [95:0] wr_data;
  logic        busy;
  logic        done;
  logic        crc_err;

  typedef struct {
    logic [6:0]  addr;
    logic [95:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  tb_xor = 8'h00;
  logic [95:0] last_w = '0;

  ptcfg_loader #(.NUM_PT(NPT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .crc_err   (crc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && wr_en) begin
      wr_t e;
      wr_cnt++;
      chk("wr_expected", 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 96'(wr_addr), 96'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit last);
    int n;
    if (gap) begin
      cfg_valid = 1'b0;
      step();
    end
    cfg_data  = b;
    cfg_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready", 96'(cfg_ready), 96'd1);
    step();
    if (last) chk("wr_latency", 96'(wr_en), 96'd1);
  endtask

  // mode 0: base+k, 1: all 0xFF, 2: random; poke_k pulses start before byte poke_k
  task automatic send_pt(input int addr, input int mode, input logic [7:0] base,
                         input bit gap, input int poke_k);
    logic [7:0]  bytes[12];
    logic [7:0]  b;
    logic [95:0] w;
    w = '0;
    for (int k = 0; k < 12; k++) begin
      case (mode)
        0:       b = base + 8'(k);
        1:       b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      for (int j = 0; j < 8; j++) w[8*k + j] = b[7-j];
      bytes[k] = b;
      tb_xor ^= b;
    end
    exp_q.push_back('{addr: 7'(addr), data: w});
    last_w = w;
    for (int k = 0; k < 12; k++) begin
      if (k == poke_k) begin
        cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_busy", 96'(busy), 96'd1);
      end
      send_byte(bytes[k], gap, k == 11);
    end
  endtask

  task automatic do_start();
    tb_xor = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 96'(busy), 96'd1);
  endtask

  task automatic finish_load(input bit exp_crc, input logic [7:0] trailer);
    cfg_valid = 1'b0;
`ifdef PTCFG_CHECKSUM_EN
    send_byte(trailer, 1'b0, 1'b0);
    cfg_valid = 1'b0;
`else
    step();
`endif
    chk("done_pulse", 96'(done), 96'd1);
    chk("done_busy", 96'(busy), 96'd1);
    step();
    chk("done_clear", 96'(done), 96'd0);
    chk("idle_busy", 96'(busy), 96'd0);
    chk("crc_err", 96'(crc_err), 96'(exp_crc));
  endtask

  task automatic chk_zero_outputs();
    chk("rst_cfg_ready", 96'(cfg_ready), 96'd0);
    chk("rst_wr_en", 96'(wr_en), 96'd0);
    chk("rst_wr_addr", 96'(wr_addr), 96'd0);
    chk("rst_wr_data", wr_data, 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_crc_err", 96'(crc_err), 96'd0);
  endtask

  initial begin
    int w0;
    int d0;

    rst_n = 1'b0;
    repeat (3) step();
    chk_zero_outputs();
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", 96'(busy), 96'd0);

    // abort alone, then start together with abort, in IDLE
    abort = 1'b1;
    step();
    chk("abort_idle", 96'(busy), 96'd0);
    start = 1'b1;
    step();
    chk("start_abort_idle", 96'(busy), 96'd0);
    start = 1'b0;
    abort = 1'b0;

    // bytes 0x00..0x17 with cfg_valid held high
    do_start();
    chk("load_ready", 96'(cfg_ready), 96'd1);
    send_pt(0, 0, 8'h00, 1'b0, -1);
    send_pt(1, 0, 8'h0C, 1'b0, -1);
    finish_load(1'b0, tb_xor);
    chk("hold_addr", 96'(wr_addr), 96'd1);
    chk("hold_data", wr_data, last_w);

    // same data with cfg_valid toggling
    do_start();
    send_pt(0, 0, 8'h00, 1'b1, -1);
    send_pt(1, 0, 8'h0C, 1'b1, -1);
    finish_load(1'b0, tb_xor);

    // abort after byte 5 of PT 1
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start();
    send_pt(0, 2, 8'h00, 1'b0, -1);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h40 + k), 1'b0, 1'b0);
    cfg_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_to_idle", 96'(busy), 96'd0);
    chk("abort_ready", 96'(cfg_ready), 96'd0);
    repeat (4) step();
    chk("abort_wr_count", 96'(wr_cnt - w0), 96'd1);
    chk("abort_no_done", 96'(done_cnt - d0), 96'd0);
    chk("abort_hold_addr", 96'(wr_addr), 96'd0);

    // start pulsed mid-LOAD, then reset at PT 1 byte 3
    do_start();
    send_pt(0, 0, 8'h80, 1'b0, 4);
    for (int k = 0; k < 3; k++) send_byte(8'(8'hA0 + k), 1'b0, 1'b0);
    cfg_data = 8'hA3;
    cfg_valid = 1'b1;
    rst_n = 1'b0;
    step();
    chk_zero_outputs();
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // fresh random load after the mid-sequence reset
    do_start();
    send_pt(0, 2, 8'h00, 1'b0, -1);
    send_pt(1, 2, 8'h00, 1'b1, -1);
    finish_load(1'b0, tb_xor);

`ifdef PTCFG_CHECKSUM_EN
    do_start();
    send_pt(0, 1, 8'h00, 1'b0, -1);
    send_pt(1, 1, 8'h00, 1'b0, -1);
    finish_load(1'b0, 8'h00);
    do_start();
    send_pt(0, 1, 8'h00, 1'b0, -1);
    send_pt(1, 1, 8'h00, 1'b0, -1);
    finish_load(1'b1, 8'h01);
    step();
    chk("crc_sticky", 96'(crc_err), 96'd1);
    do_start();
    chk("crc_cleared", 96'(crc_err), 96'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    repeat (3) step();
    chk("sb_empty", 96'(exp_q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ptcfg_loader.md
PTCFG_LOADER -- requirements
Module: ptcfg_loader

Interface
REQ-001 Parameter NUM_PT, default 80: number of product terms loaded, legal range 1..128.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  begins a load sequence; honoured only in IDLE.
REQ-005 abort  input  1  cancels a sequence in progress.
REQ-006 cfg_valid  input  1  cfg_data holds a byte.
REQ-007 cfg_data  input  8  configuration byte, MSB first.
REQ-008 cfg_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  one-cycle write strobe to the product-term bitmap store.
REQ-010 wr_addr  output  7  product-term index being written.
REQ-011 wr_data  output  96  assembled ptbitmap_mux word, index 0..95.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 crc_err  output  1  sticky checksum mismatch flag.

Function
REQ-015 States SHALL be IDLE, LOAD, COMMIT, CHECK and DONE.
REQ-016 IDLE: cfg_ready=0; start=1 with abort=0 -> LOAD; clears byte counter, PT counter and crc_err.
REQ-017 LOAD: cfg_ready=1; a byte is consumed only when cfg_valid and cfg_ready are both 1; otherwise the input is held and not consumed.
REQ-018 Byte k (0..11) of a PT SHALL land in wr_data[8k..8k+7], with cfg_data[7] at index 8k and cfg_data[0] at index 8k+7.
REQ-019 Handshake of byte 11 -> COMMIT next cycle.
REQ-020 COMMIT: wr_en=1 for exactly one cycle; wr_addr=PT counter; cfg_ready=0.
REQ-021 After COMMIT, PT counter increments; if NUM_PT PTs are now written -> CHECK (macro on) or DONE (macro off); otherwise -> LOAD with byte counter 0.
REQ-022 DONE: done=1 for one cycle, then -> IDLE.
REQ-023 Write latency: wr_en SHALL assert in the cycle after the 12th byte handshake of each PT.
REQ-024 wr_data and wr_addr SHALL hold their last values outside COMMIT.
REQ-025 start in any non-IDLE state SHALL be ignored.
REQ-026 abort in LOAD, COMMIT or CHECK -> IDLE next cycle: no wr_en that cycle, no done, partial PT discarded, PTs already committed remain written.
REQ-027 abort in IDLE or DONE SHALL have no effect; start and abort both high in IDLE -> remain IDLE.
REQ-028 Counters SHALL never wrap: byte counter range 0..11, PT counter range 0..NUM_PT.

Reset
REQ-029 rst_n=0 at a clock edge -> IDLE; all outputs 0; wr_data, counters and checksum accumulator cleared; this applies mid-sequence as well.

Configuration
REQ-030 Macro PTCFG_CHECKSUM_EN defined: the loader XORs all 12*NUM_PT data bytes.
REQ-031 With the macro defined, CHECK sets cfg_ready=1 and accepts one trailing byte; on its handshake, a mismatch sets crc_err=1, and the state goes -> DONE either way.
REQ-032 Macro PTCFG_CHECKSUM_EN undefined: CHECK is unreachable, crc_err is tied 0, and no accumulator is built.

Structure
REQ-033 Package ptcfg_pkg SHALL hold the state enum, PT_BITS=96, BYTES_PER_PT=12 and ADDR_W=7.
REQ-034 The byte-to-word assembler SHALL be a sub-module ptcfg_shifter with inputs load, byte_idx and byte, and output word.
REQ-035 Control logic and checksum SHALL stay in ptcfg_loader.

Verification
REQ-036 NUM_PT=2, 24 bytes 0x00..0x17 with cfg_valid held high -> two wr_en pulses at addr 0 then addr 1; addr-0 word starts 0x000102..; done 1 cycle after the last commit (macro off).
REQ-037 cfg_valid toggled 1/0 every cycle -> identical wr_data and addresses; each wr_en 1 cycle after the 12th byte.
REQ-038 abort asserted after byte 5 of PT 1 -> IDLE next cycle; exactly one wr_en total (addr 0); done stays 0.
REQ-039 start pulsed during LOAD -> no restart; counters continue; rst_n=0 at PT 1 byte 3 -> all outputs 0 next cycle.
REQ-040 Macro on, NUM_PT=1, bytes all 0xFF plus trailer 0x00 -> crc_err=0; trailer 0x01 -> crc_err=1, done pulses, crc_err cleared by next start.
